// File: rtl/mac_acc_stream.sv
// Pipelined signed multiply-accumulate engine with bias preload,
// round/shift requantisation, optional ReLU, saturation and flow control.
module mac_acc_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 4,
  parameter int CNT_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic signed [ACC_W-1:0]  in_bias,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]         out_cnt,
  output logic                     out_acc_ovf
);

  localparam logic [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AMIN = ~AMAX;
  localparam logic signed [ACC_W:0] OMAX =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = ~OMAX;
  localparam logic signed [ACC_W:0] RND =
    ((ACC_W+1)'(1) << SHIFT) >> 1;

  logic w_en;
  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;

  logic                     r_s1_v, r_s1_first, r_s1_last, r_s1_relu;
  logic signed [DATA_W-1:0] r_s1_a, r_s1_b;
  logic signed [ACC_W-1:0]  r_s1_bias;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_relu  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_bias  <= '0;
    end else if (w_en) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_first <= in_first;
        r_s1_last  <= in_last;
        r_s1_relu  <= relu_en;
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
        r_s1_bias  <= in_bias;
      end
    end
  end

  logic signed [2*DATA_W-1:0] w_prod;
  assign w_prod = r_s1_a * r_s1_b;

  logic                    r_s2_v, r_s2_first, r_s2_last, r_s2_relu;
  logic signed [ACC_W-1:0] r_s2_prod, r_s2_bias;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v     <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_relu  <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_bias  <= '0;
    end else if (w_en) begin
      r_s2_v     <= r_s1_v;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_relu  <= r_s1_relu;
      r_s2_prod  <= ACC_W'(w_prod);
      r_s2_bias  <= r_s1_bias;
    end
  end

  logic [ACC_W-1:0] r_acc, r_res;
  logic [CNT_W-1:0] r_cnt, r_res_cnt;
  logic             r_ovf, r_relu, r_s3_v;
  logic             r_res_ovf, r_res_relu;

  logic [ACC_W-1:0] w_base, w_sat;
  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_base, w_cnt_nx;
  logic             w_sovf, w_ovf_nx, w_relu_nx;

  always_comb begin
    w_base     = r_s2_first ? r_s2_bias : r_acc;
    w_sum      = {w_base[ACC_W-1], w_base}
               + {r_s2_prod[ACC_W-1], r_s2_prod};
    w_sovf     = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    w_sat      = w_sovf ? (w_sum[ACC_W] ? AMIN : AMAX)
                        : w_sum[ACC_W-1:0];
    w_cnt_base = r_s2_first ? '0 : r_cnt;
    w_cnt_nx   = (&w_cnt_base) ? w_cnt_base
                               : w_cnt_base + CNT_W'(1);
    w_ovf_nx   = (r_s2_first ? 1'b0 : r_ovf) | w_sovf;
    w_relu_nx  = r_s2_first ? r_s2_relu : r_relu;
  end

  // A last beat hands its total to S4 and leaves the accumulator at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3_v     <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_relu     <= 1'b0;
      r_res      <= '0;
      r_res_cnt  <= '0;
      r_res_ovf  <= 1'b0;
      r_res_relu <= 1'b0;
    end else if (w_en) begin
      r_s3_v <= r_s2_v && r_s2_last;
      if (r_s2_v) begin
        if (r_s2_last) begin
          r_acc      <= '0;
          r_cnt      <= '0;
          r_ovf      <= 1'b0;
          r_relu     <= 1'b0;
          r_res      <= w_sat;
          r_res_cnt  <= w_cnt_nx;
          r_res_ovf  <= w_ovf_nx;
          r_res_relu <= w_relu_nx;
        end else begin
          r_acc  <= w_sat;
          r_cnt  <= w_cnt_nx;
          r_ovf  <= w_ovf_nx;
          r_relu <= w_relu_nx;
        end
      end
    end
  end

  logic signed [ACC_W:0]   w_r, w_sh;
  logic signed [OUT_W-1:0] w_q;

  always_comb begin
    w_r = $signed({r_res[ACC_W-1], r_res}) + RND;
    w_sh = w_r >>> SHIFT;
    if (r_res_relu && (w_sh < 0)) w_q = '0;
    else if (w_sh > OMAX)         w_q = OMAX[OUT_W-1:0];
    else if (w_sh < OMIN)         w_q = OMIN[OUT_W-1:0];
    else                          w_q = w_sh[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_cnt     <= '0;
      out_acc_ovf <= 1'b0;
    end else if (w_en) begin
      out_valid <= r_s3_v;
      if (r_s3_v) begin
        out_data    <= w_q;
        out_cnt     <= r_res_cnt;
        out_acc_ovf <= r_res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_stream.sv
// Randomised and directed bench for mac_acc_stream against a
// packet-level arithmetic model.
module tb_mac_acc_stream;

  localparam int SHIFT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready, in_ready16;
  logic signed [7:0] in_a = '0, in_b = '0;
  logic              in_first = 1'b0, in_last = 1'b0;
  logic [31:0]       in_bias = '0;
  logic              relu_en = 1'b0;
  logic              out_valid, out_valid16;
  logic              out_ready = 1'b1;
  logic signed [7:0] out_data, out_data16;
  logic [9:0]        out_cnt, out_cnt16;
  logic              out_acc_ovf, out_ovf16;

  int total = 0;
  int bad   = 0;

  typedef logic [18:0] res_t;
  res_t got[$], got16[$], exp_q[$];
  int   pa[$], pb[$];
  bit   tog_done;

  always #5 clk = ~clk;

  mac_acc_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last),
    .in_bias(in_bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt),
    .out_acc_ovf(out_acc_ovf)
  );

  mac_acc_stream #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last),
    .in_bias(in_bias[15:0]), .relu_en(relu_en),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_data(out_data16), .out_cnt(out_cnt16),
    .out_acc_ovf(out_ovf16)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready)
        got.push_back({out_data, out_cnt, out_acc_ovf});
      if (out_valid16 && out_ready)
        got16.push_back({out_data16, out_cnt16, out_ovf16});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Packet result from plain arithmetic: saturating running sum,
  // round-half-up shift, optional ReLU, clamp to 8 bits.
  function automatic res_t ref_pkt(input int accw, input longint bias,
                                   input bit relu);
    longint acc, mx, mn, r;
    bit ovf;
    int n;
    mx = (longint'(1) <<< (accw - 1)) - 1;
    mn = -mx - 1;
    ovf = 1'b0;
    acc = bias;
    n = pa.size();
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'(pa[i] * pb[i]);
      if (acc > mx) begin acc = mx; ovf = 1'b1; end
      else if (acc < mn) begin acc = mn; ovf = 1'b1; end
    end
    r = acc + ((longint'(1) <<< SHIFT) / 2);
    r = r >>> SHIFT;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return {8'(r), 10'(n), ovf};
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_beat(input int a, input int b, input bit f,
                           input bit l, input longint bias,
                           input bit relu);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_a = 8'(a);
    in_b = 8'(b);
    in_first = f;
    in_last = l;
    in_bias = 32'(bias);
    relu_en = relu;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=0 want=1");
    end
  endtask

  task automatic send_stored(input longint bias, input bit relu,
                             input bit use_first);
    int n;
    n = pa.size();
    for (int i = 0; i < n; i++)
      send_beat(pa[i], pb[i], use_first && i == 0, i == n - 1,
                bias, relu);
    exp_q.push_back(ref_pkt(32, use_first ? bias : 0,
                            use_first ? relu : 1'b0));
  endtask

  task automatic wait_results();
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic compare_results(input string name);
    int m;
    total++;
    if (got.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s count got=%0d want=%0d", name, got.size(),
               exp_q.size());
    end
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s[%0d] got d=%0d c=%0d o=%0b want d=%0d c=%0d o=%0b",
                 name, i, $signed(got[i][18:11]), got[i][10:1],
                 got[i][0], $signed(exp_q[i][18:11]),
                 exp_q[i][10:1], exp_q[i][0]);
      end
    end
    got.delete();
    got16.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_data, out_cnt, out_acc_ovf} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outs got=%h want=0",
               {out_valid, out_data, out_cnt, out_acc_ovf});
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_basic();
    pa = '{10, 10, 10};
    pb = '{20, 20, 20};
    out_ready = 1'b1;
    send_stored(16, 1'b0, 1'b1);
    idle();
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      total++;
      if (out_valid !== (i == 3)) begin
        bad++;
        $display("FAIL basic_latency edge+%0d got=%b want=%b", i,
                 out_valid, i == 3);
      end
    end
    total++;
    if ({out_data, out_cnt, out_acc_ovf} !== {8'sd39, 10'd3, 1'b0}) begin
      bad++;
      $display("FAIL basic_result got d=%0d c=%0d o=%b want d=39 c=3 o=0",
               out_data, out_cnt, out_acc_ovf);
    end
    wait_results();
    compare_results("basic");
  endtask

  task automatic test_single();
    pa = '{-10};
    pb = '{20};
    send_stored(0, 1'b0, 1'b1);
    send_stored(0, 1'b1, 1'b1);
    idle();
    wait_results();
    total++;
    if (got.size() < 2 || got[0][18:11] !== 8'hF4 ||
        got[1][18:11] !== 8'h00) begin
      bad++;
      $display("FAIL single_relu got n=%0d want -12 then 0", got.size());
    end
    compare_results("single");
  endtask

  task automatic test_sat();
    pa = '{127, 127, 127, 127};
    pb = '{127, 127, 127, 127};
    send_stored(0, 1'b0, 1'b1);
    idle();
    wait_results();
    total++;
    if (got.size() < 1 || got[0] !== {8'd127, 10'd4, 1'b0}) begin
      bad++;
      $display("FAIL out_sat got n=%0d want d=127 c=4 o=0", got.size());
    end
    compare_results("sat");
  endtask

  task automatic test_acc16();
    pa = '{-128, -128};
    pb = '{-128, -128};
    send_stored(0, 1'b0, 1'b1);
    pa = '{1};
    pb = '{1};
    send_stored(0, 1'b0, 1'b1);
    idle();
    wait_results();
    total++;
    if (got16.size() != 2) begin
      bad++;
      $display("FAIL acc16_count got=%0d want=2", got16.size());
    end else begin
      total++;
      if (got16[0] !== {8'd127, 10'd2, 1'b1}) begin
        bad++;
        $display("FAIL acc16_ovf got=%h want=%h", got16[0],
                 {8'd127, 10'd2, 1'b1});
      end
      total++;
      if (got16[1] !== {8'd0, 10'd1, 1'b0}) begin
        bad++;
        $display("FAIL acc16_clear got=%h want=%h", got16[1],
                 {8'd0, 10'd1, 1'b0});
      end
    end
    compare_results("acc16_main");
  endtask

  task automatic test_stall();
    logic [7:0] d;
    logic [9:0] c;
    int n;
    out_ready = 1'b0;
    fork
      begin
        pa = '{3, -7};
        pb = '{-5, 9};
        send_stored(100, 1'b0, 1'b1);
        pa = '{50, 60, -70};
        pb = '{2, 3, 4};
        send_stored(-40, 1'b1, 1'b1);
        idle();
      end
      begin
        n = 0;
        while (!out_valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        d = out_data;
        c = out_cnt;
        repeat (5) begin
          @(posedge clk);
          #1;
          total++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
              out_data !== d || out_cnt !== c) begin
            bad++;
            $display("FAIL stall_hold got r=%b v=%b d=%0d c=%0d want r=0 v=1 d=%0d c=%0d",
                     in_ready, out_valid, out_data, out_cnt, d, c);
          end
        end
        out_ready = 1'b1;
      end
    join
    wait_results();
    compare_results("stall");
  endtask

  task automatic test_random();
    int n;
    longint bias;
    bit relu;
    tog_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 30; p++) begin
          n = $urandom_range(1, 16);
          pa.delete();
          pb.delete();
          for (int i = 0; i < n; i++) begin
            pa.push_back(int'($urandom_range(0, 255)) - 128);
            pb.push_back(int'($urandom_range(0, 255)) - 128);
          end
          if ($urandom_range(0, 7) == 0)
            bias = 64'sd2147480000;
          else
            bias = longint'($urandom_range(0, 2097152)) - 1048576;
          relu = 1'($urandom_range(0, 1));
          send_stored(bias, relu, 1'b1);
        end
        idle();
        tog_done = 1'b1;
      end
      begin
        while (!tog_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_results();
    compare_results("random");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send_beat(40, 50, i == 0, 1'b0, 1000, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pa = '{-30, 25};
    pb = '{11, 7};
    send_stored(0, 1'b0, 1'b0);
    pa = '{6, 6, 6};
    pb = '{-9, 4, 100};
    send_stored(-500, 1'b1, 1'b1);
    idle();
    wait_results();
    compare_results("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_sat();
    test_acc16();
    test_stall();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
